// File: rtl/sweep_cmd_scheduler.sv
// Host command sequencer: pops 11-byte commands from the RX FIFO, validates them and
// drives the sweeper (valid/ready) or the PLL. Optional inter-byte timeout: SWEEP_CMD_TIMEOUT_EN.
module sweep_cmd_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [31:0] cfg_freq_step,
  output logic [15:0] cfg_cycles,
  output logic [31:0] cfg_init_freq,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic        sweep_done,
  output logic        pll_enable,
  output logic        busy,
  output logic        err_pulse,
  output logic [1:0]  err_code
);

  localparam int unsigned ASM_W     = 88;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LAST_BYTE = 10;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CAPTURE,
    S_CHECK,
    S_DISPATCH,
    S_WAIT_DONE,
    S_PLL_ON
  } state_t;

  state_t             state;
  logic [ASM_W-1:0]   asm_q;
  logic [CNT_W-1:0]   byte_cnt;
  logic               timeout_hit;

  logic [31:0]        asm_freq_step;
  logic [15:0]        asm_cycles;
  logic [31:0]        asm_init_freq;
  logic [7:0]         asm_mode;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sweep_cmd_scheduler: TIMEOUT_CYCLES must be at least 2");
  end

  // First received byte ends up in the low byte after eleven right shifts
  assign asm_freq_step = asm_q[31:0];
  assign asm_cycles    = asm_q[47:32];
  assign asm_init_freq = asm_q[79:48];
  assign asm_mode      = asm_q[87:80];

  // Pop strobe is combinational so a byte can be requested the cycle the FIFO fills
  assign fifo_rd_en = !reset && (state == S_COLLECT) && !fifo_empty && !timeout_hit;

`ifdef SWEEP_CMD_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_cnt;

  assign timeout_hit = (state == S_COLLECT) && (byte_cnt != CNT_W'(0)) &&
                       (gap_cnt == GAP_W'(TIMEOUT_CYCLES));

  // Idle cycles spent waiting for the next byte of a partially received command
  always_ff @(posedge clk_50m) begin
    if (reset || (state != S_COLLECT) || fifo_rd_en || timeout_hit || (byte_cnt == CNT_W'(0))) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state         <= S_COLLECT;
      asm_q         <= '0;
      byte_cnt      <= '0;
      cfg_freq_step <= '0;
      cfg_cycles    <= '0;
      cfg_init_freq <= '0;
      cmd_valid     <= 1'b0;
      pll_enable    <= 1'b0;
      busy          <= 1'b0;
      err_pulse     <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (timeout_hit) begin
            byte_cnt  <= '0;
            err_code  <= 2'd3;
            err_pulse <= 1'b1;
          end else if (fifo_rd_en) begin
            state <= S_CAPTURE;
            busy  <= 1'b1;
          end
        end

        S_CAPTURE: begin
          asm_q <= {fifo_data, asm_q[ASM_W-1:8]};
          if (byte_cnt == CNT_W'(LAST_BYTE)) begin
            byte_cnt <= '0;
            state    <= S_CHECK;
          end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            state    <= S_COLLECT;
            busy     <= 1'b0;
          end
        end

        S_CHECK: begin
          if (asm_mode > 8'd1) begin
            err_code  <= 2'd1;
            err_pulse <= 1'b1;
            state     <= S_COLLECT;
            busy      <= 1'b0;
          end else if ((asm_mode == 8'd0) && (asm_cycles == 16'd0)) begin
            err_code  <= 2'd2;
            err_pulse <= 1'b1;
            state     <= S_COLLECT;
            busy      <= 1'b0;
          end else begin
            // Dropping the PLL here guarantees a low cycle before any re-enable
            cfg_freq_step <= asm_freq_step;
            cfg_cycles    <= asm_cycles;
            cfg_init_freq <= asm_init_freq;
            pll_enable    <= 1'b0;
            if (asm_mode == 8'd0) begin
              cmd_valid <= 1'b1;
              state     <= S_DISPATCH;
            end else begin
              state <= S_PLL_ON;
            end
          end
        end

        S_DISPATCH: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (sweep_done) begin
            state <= S_COLLECT;
            busy  <= 1'b0;
          end
        end

        S_PLL_ON: begin
          pll_enable <= 1'b1;
          state      <= S_COLLECT;
          busy       <= 1'b0;
        end

        default: begin
          state <= S_COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
